// File: rtl/map_overlay_cached_if.sv
// Map ROM port shared between the overlay row-cache fill engine and the
// tracer. The master raises req with a stable col/row address; the arbiter
// returns gnt together with the cell value in the same cycle.
interface map_overlay_cached_if #(
  parameter int WBITS = 4,
  parameter int HBITS = 4
);
  logic             req;
  logic             gnt;
  logic [WBITS-1:0] col;
  logic [HBITS-1:0] row;
  logic [1:0]       val;

  modport master (output req, output col, output row, input gnt, input val);
  modport slave  (input req, input col, input row, output gnt, output val);
endinterface

// File: rtl/map_overlay_cached.sv
// Top-down map overlay with a one-row cell cache. While the overlay is on
// screen it draws only from the cache; the next map row is fetched during
// hblank through a req/gnt handshake, so the ROM port stays free for the
// tracer during visible pixels.
module map_overlay_cached #(
  parameter int H_VIEW    = 640,
  parameter int V_TOTAL   = 525,
  parameter int MAP_WBITS = 4,
  parameter int MAP_HBITS = 4,
  parameter int MAP_SCALE = 3,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 i_enable,
  input  logic [MAP_WBITS-1:0] i_player_cx,
  input  logic [MAP_HBITS-1:0] i_player_cy,
  input  logic [MAP_SCALE-1:0] i_player_fx,
  input  logic [MAP_SCALE-1:0] i_player_fy,
  map_overlay_cached_if.master rom,
  input  logic                 i_miss_clr,
  output logic                 o_fill_miss,
  output logic                 in_map_overlay,
  output logic [5:0]           map_rgb
);

  localparam int MAP_WIDTH = 1 << MAP_WBITS;
  localparam logic [9:0] ORG_X  = 10'(ORIGIN_X);
  localparam logic [9:0] ORG_Y  = 10'(ORIGIN_Y);
  localparam logic [9:0] OV_W   = 10'(MAP_WIDTH << MAP_SCALE);
  localparam logic [9:0] OV_H   = 10'((1 << MAP_HBITS) << MAP_SCALE);
  localparam logic [9:0] HBLANK = 10'(H_VIEW);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [MAP_WBITS-1:0] COL_LAST = {MAP_WBITS{1'b1}};
  localparam logic [MAP_SCALE-1:0] FRAC_ZERO = {MAP_SCALE{1'b0}};

  // Colours, BBGGRR
  localparam logic [5:0] C_PLAYER_PIX  = 6'b00_11_11;
  localparam logic [5:0] C_PLAYER_CELL = 6'b00_01_00;
  localparam logic [5:0] C_GRID        = 6'b01_00_00;
  localparam logic [5:0] C_MISS        = 6'b11_00_11;
  localparam logic [5:0] C_VAL0        = 6'b00_00_00;
  localparam logic [5:0] C_VAL1        = 6'b11_00_00;
  localparam logic [5:0] C_VAL2        = 6'b00_11_11;
  localparam logic [5:0] C_VAL3        = 6'b00_00_11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  fill_state_e          state_r;
  logic                 req_r;
  logic [MAP_WBITS-1:0] col_r;
  logic [MAP_HBITS-1:0] row_r;
  logic [1:0]           cache_val_r [MAP_WIDTH];
  logic [MAP_WIDTH-1:0] cache_vld_r;
  logic                 miss_r;

  logic [9:0]           lh_s;
  logic [9:0]           lv_s;
  logic                 in_rect_s;
  logic [MAP_WBITS-1:0] cx_s;
  logic [MAP_HBITS-1:0] cy_s;
  logic [MAP_SCALE-1:0] fx_s;
  logic [MAP_SCALE-1:0] fy_s;
  logic                 grid_s;
  logic                 player_cell_s;
  logic                 player_pix_s;
  logic                 cell_vld_s;
  logic [1:0]           cell_val_s;
  logic                 miss_hit_s;
  logic [5:0]           rgb_s;
  logic [9:0]           next_line_s;
  logic [9:0]           next_rel_s;
  logic                 trig_s;
  logic [MAP_HBITS-1:0] trig_row_s;

  assign rom.req = req_r;
  assign rom.col = col_r;
  assign rom.row = row_r;
  assign o_fill_miss    = miss_r;
  assign in_map_overlay = in_rect_s;
  assign map_rgb        = rgb_s;

  // Beam position relative to the overlay and the cell / gridline / player decode.
  // The rectangle is inclusive of the far gridline, so it is one pixel wider than
  // the map; on that pixel cx/cy wrap to 0 but the gridline decode always wins.
  always_comb begin
    lh_s          = hpos - ORG_X;
    lv_s          = vpos - ORG_Y;
    in_rect_s     = i_enable && (hpos >= ORG_X) && (vpos >= ORG_Y) &&
                    (lh_s <= OV_W) && (lv_s <= OV_H);
    cx_s          = lh_s[MAP_SCALE+MAP_WBITS-1:MAP_SCALE];
    cy_s          = lv_s[MAP_SCALE+MAP_HBITS-1:MAP_SCALE];
    fx_s          = lh_s[MAP_SCALE-1:0];
    fy_s          = lv_s[MAP_SCALE-1:0];
    grid_s        = (fx_s == FRAC_ZERO) || (fy_s == FRAC_ZERO);
    player_cell_s = (cx_s == i_player_cx) && (cy_s == i_player_cy) &&
                    (lh_s < OV_W) && (lv_s < OV_H);
    player_pix_s  = player_cell_s && (fx_s == i_player_fx) && (fy_s == i_player_fy);
    cell_vld_s    = cache_vld_r[cx_s];
    cell_val_s    = cache_val_r[cx_s];
    miss_hit_s    = in_rect_s && !grid_s && !player_cell_s && !cell_vld_s;
  end

  // Overlay colour in priority order; cache contents only matter inside a cell.
  always_comb begin
    rgb_s = C_VAL0;
    if (player_pix_s) begin
      rgb_s = C_PLAYER_PIX;
    end else if (player_cell_s) begin
      rgb_s = C_PLAYER_CELL;
    end else if (grid_s) begin
      rgb_s = C_GRID;
    end else if (!cell_vld_s) begin
      rgb_s = C_MISS;
    end else begin
      case (cell_val_s)
        2'd0:    rgb_s = C_VAL0;
        2'd1:    rgb_s = C_VAL1;
        2'd2:    rgb_s = C_VAL2;
        2'd3:    rgb_s = C_VAL3;
        default: rgb_s = C_MISS;
      endcase
    end
  end

  // Hblank trigger: the line about to be drawn is the first line of a map cell row.
  always_comb begin
    next_line_s = (vpos == V_LAST) ? 10'd0 : (vpos + 10'd1);
    next_rel_s  = next_line_s - ORG_Y;
    trig_s      = (hpos == HBLANK) && (next_line_s >= ORG_Y) && (next_rel_s < OV_H) &&
                  (next_rel_s[MAP_SCALE-1:0] == FRAC_ZERO);
    trig_row_s  = next_rel_s[MAP_SCALE+MAP_HBITS-1:MAP_SCALE];
  end

  // Row-cache fill engine: holds the address stable until granted, writes one
  // cell per grant, restarts on a new trigger and drops everything on disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      req_r       <= 1'b0;
      col_r       <= {MAP_WBITS{1'b0}};
      row_r       <= {MAP_HBITS{1'b0}};
      cache_vld_r <= {MAP_WIDTH{1'b0}};
      for (int i = 0; i < MAP_WIDTH; i++) begin
        cache_val_r[i] <= 2'b00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trig_s && i_enable) begin
            state_r     <= ST_FILL;
            req_r       <= 1'b1;
            col_r       <= {MAP_WBITS{1'b0}};
            row_r       <= trig_row_s;
            cache_vld_r <= {MAP_WIDTH{1'b0}};
          end
        end
        ST_FILL: begin
          if (!i_enable) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            cache_vld_r <= {MAP_WIDTH{1'b0}};
          end else if (trig_s) begin
            col_r       <= {MAP_WBITS{1'b0}};
            row_r       <= trig_row_s;
            cache_vld_r <= {MAP_WIDTH{1'b0}};
          end else if (rom.gnt) begin
            cache_val_r[col_r] <= rom.val;
            cache_vld_r[col_r] <= 1'b1;
            col_r              <= col_r + {{(MAP_WBITS-1){1'b0}}, 1'b1};
            if (col_r == COL_LAST) begin
              state_r <= ST_IDLE;
              req_r   <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_r       <= 1'b0;
          cache_vld_r <= {MAP_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Sticky flag for cells drawn before their cache entry arrived; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_r <= 1'b0;
    end else if (i_miss_clr) begin
      miss_r <= 1'b0;
    end else if (miss_hit_s) begin
      miss_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_map_overlay_cached.sv
// Directed bench for map_overlay_cached: a default-origin instance and a
// relocated (100,50) instance share the beam; each has its own ROM model.
module tb_map_overlay_cached;

  localparam logic [5:0] C_PPIX  = 6'b001111;
  localparam logic [5:0] C_PCELL = 6'b000100;
  localparam logic [5:0] C_GRID  = 6'b010000;
  localparam logic [5:0] C_MISS  = 6'b110011;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hpos, vpos;
  logic       enable;
  logic [3:0] pcx, pcy;
  logic [2:0] pfx, pfy;
  logic       miss_clr;
  logic       miss, in_ov, miss_o, in_ov_o;
  logic [5:0] rgb, rgb_o;
  int         gnt_mode, gnt_mode_o, rom_mode;
  logic [1:0] gcnt = 2'd0;
  int         n_assert = 0;
  int         n_fail = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  map_overlay_cached_if #(.WBITS(4), .HBITS(4)) rif ();
  map_overlay_cached_if #(.WBITS(4), .HBITS(4)) rif_o ();

  map_overlay_cached dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .i_enable(enable),
    .i_player_cx(pcx), .i_player_cy(pcy), .i_player_fx(pfx), .i_player_fy(pfy),
    .rom(rif.master), .i_miss_clr(miss_clr), .o_fill_miss(miss),
    .in_map_overlay(in_ov), .map_rgb(rgb)
  );

  map_overlay_cached #(.ORIGIN_X(100), .ORIGIN_Y(50)) dut_o (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .i_enable(enable),
    .i_player_cx(pcx), .i_player_cy(pcy), .i_player_fx(pfx), .i_player_fy(pfy),
    .rom(rif_o.master), .i_miss_clr(miss_clr), .o_fill_miss(miss_o),
    .in_map_overlay(in_ov_o), .map_rgb(rgb_o)
  );

  always #5 clk = ~clk;

  // Map ROM contents: mode 0 is col%4, mode 1 mixes in the row.
  function automatic logic [1:0] rom_f(int mode, logic [3:0] row, logic [3:0] col);
    if (mode == 0) return col[1:0];
    return 2'(int'(col) * 3 + int'(row));
  endfunction

  function automatic logic [5:0] val_colour(logic [1:0] v);
    case (v)
      2'd0:    return 6'b000000;
      2'd1:    return 6'b110000;
      2'd2:    return 6'b001111;
      default: return 6'b000011;
    endcase
  endfunction

  // Grant pattern phase counter for the 1-in-3 mode.
  always @(posedge clk) gcnt <= (gcnt == 2'd2) ? 2'd0 : gcnt + 2'd1;

  assign rif.gnt   = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : (gcnt == 2'd0);
  assign rif.val   = rom_f(rom_mode, rif.row, rif.col);
  assign rif_o.gnt = (gnt_mode_o == 0);
  assign rif_o.val = rom_f(0, rif_o.row, rif_o.col);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string tag, logic [15:0] e);
    sb_q.push_back('{tag: tag, exp: e});
  endtask

  task automatic compare(logic [15:0] obs);
    sb_t s;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h, expected nothing queued", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] e);
    expect_v(tag, e);
    compare(obs);
  endtask

  // Place the beam, check overlay flag and (when inside) colour, then clock once.
  task automatic pix(bit o, int h, int v, logic ein, logic [5:0] ergb);
    hpos = 10'(h);
    vpos = 10'(v);
    expect_v($sformatf("in%s@%0d,%0d", o ? "_o" : "", h, v), 16'(ein));
    if (ein) expect_v($sformatf("rgb%s@%0d,%0d", o ? "_o" : "", h, v), 16'(ergb));
    #1;
    compare(o ? 16'(in_ov_o) : 16'(in_ov));
    if (ein) compare(o ? 16'(rgb_o) : 16'(rgb));
    tick();
  endtask

  task automatic start_fill(int v);
    hpos = 10'd640;
    vpos = 10'(v);
    tick();
    hpos = 10'd0;
    vpos = 10'd0;
  endtask

  initial begin
    int   cnt;
    bit   bad, done, p_req, p_gnt;
    logic [3:0] p_col, p_row;

    reset_n = 1'b0; hpos = 10'd0; vpos = 10'd0; enable = 1'b1;
    pcx = 4'd15; pcy = 4'd15; pfx = 3'd0; pfy = 3'd0; miss_clr = 1'b0;
    gnt_mode = 0; gnt_mode_o = 1; rom_mode = 0;
    repeat (3) tick();
    chk("rst_req_async", 16'(rif.req), 16'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_req", 16'(rif.req), 16'd0);
    chk("rst_col", 16'(rif.col), 16'd0);
    chk("rst_row", 16'(rif.row), 16'd0);
    chk("rst_miss", 16'(miss), 16'd0);
    chk("rst_req_o", 16'(rif_o.req), 16'd0);

    // 1: fill of row 0 from the last line, grant always high.
    hpos = 10'd640; vpos = 10'd524;
    tick();
    hpos = 10'd641;
    chk("t1_row", 16'(rif.row), 16'd0);
    cnt = 0; bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rif.req) begin
        if (rif.col !== 4'(cnt)) bad = 1'b1;
        cnt++;
      end
      tick();
    end
    chk("t1_req_cycles", 16'(cnt), 16'd16);
    chk("t1_col_sequence", 16'(bad), 16'd0);
    chk("t1_req_dropped", 16'(rif.req), 16'd0);

    // 2: row 0 cells and gridlines, including the inclusive far edges.
    for (int c = 0; c < 16; c++) pix(1'b0, c * 8 + 4, 4, 1'b1, val_colour(2'(c)));
    pix(1'b0, 8, 4, 1'b1, C_GRID);
    pix(1'b0, 40, 0, 1'b1, C_GRID);
    pix(1'b0, 128, 4, 1'b1, C_GRID);
    pix(1'b0, 129, 4, 1'b0, 6'd0);
    pix(1'b0, 4, 128, 1'b1, C_GRID);
    pix(1'b0, 4, 129, 1'b0, 6'd0);
    chk("t2_miss", 16'(miss), 16'd0);

    // Trigger boundaries: mid-cell line and past the map bottom must not fire.
    hpos = 10'd640; vpos = 10'd24; tick();
    chk("no_trig_midcell", 16'(rif.req), 16'd0);
    vpos = 10'd127; tick();
    chk("no_trig_below_map", 16'(rif.req), 16'd0);
    vpos = 10'd119; tick();
    chk("trig_last_row_req", 16'(rif.req), 16'd1);
    chk("trig_last_row", 16'(rif.row), 16'd15);
    hpos = 10'd0; vpos = 10'd0;
    repeat (20) tick();

    // 3: player marker on cell (2,3), fraction (4,4).
    pcx = 4'd2; pcy = 4'd3; pfx = 3'd4; pfy = 3'd4;
    start_fill(23);
    chk("t3_row", 16'(rif.row), 16'd3);
    repeat (20) tick();
    chk("t3_done", 16'(rif.req), 16'd0);
    pix(1'b0, 20, 28, 1'b1, C_PPIX);
    pix(1'b0, 17, 25, 1'b1, C_PCELL);
    pix(1'b0, 16, 24, 1'b1, C_PCELL);
    pix(1'b0, 24, 28, 1'b1, C_GRID);
    pix(1'b0, 43, 27, 1'b1, val_colour(2'd1));
    chk("t3_miss", 16'(miss), 16'd0);

    // 4: no grant -> miss colour, sticky flag, clear priority, disable abort.
    gnt_mode = 1;
    start_fill(7);
    chk("t4_row", 16'(rif.row), 16'd1);
    pix(1'b0, 43, 12, 1'b1, C_MISS);
    chk("t4_miss_set", 16'(miss), 16'd1);
    miss_clr = 1'b1;
    tick();
    chk("t4_clr_wins", 16'(miss), 16'd0);
    miss_clr = 1'b0; hpos = 10'd40;
    tick();
    chk("t4_miss_stays_clr", 16'(miss), 16'd0);
    chk("t4_req_waiting", 16'(rif.req), 16'd1);
    chk("t4_col_held", 16'(rif.col), 16'd0);
    enable = 1'b0;
    #1;
    chk("t4_disable_ov", 16'(in_ov), 16'd0);
    tick();
    chk("t4_abort_req", 16'(rif.req), 16'd0);
    enable = 1'b1;
    pix(1'b0, 43, 12, 1'b1, C_MISS);
    miss_clr = 1'b1; tick(); miss_clr = 1'b0;

    // 5: grant one cycle in three, row-dependent ROM data.
    gnt_mode = 2; rom_mode = 1;
    start_fill(15);
    chk("t5_row", 16'(rif.row), 16'd2);
    bad = 1'b0; done = 1'b0; p_req = 1'b0; p_gnt = 1'b0; p_col = 4'd0; p_row = 4'd0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (p_req && !p_gnt && rif.req && (rif.col !== p_col || rif.row !== p_row)) bad = 1'b1;
      if (!rif.req) done = 1'b1;
      p_req = rif.req; p_gnt = rif.gnt; p_col = rif.col; p_row = rif.row;
      tick();
    end
    chk("t5_fill_done", 16'(done), 16'd1);
    chk("t5_addr_stable", 16'(bad), 16'd0);
    for (int c = 0; c < 16; c++) pix(1'b0, c * 8 + 4, 20, 1'b1, val_colour(rom_f(1, 4'd2, 4'(c))));
    chk("t5_miss", 16'(miss), 16'd0);

    // 6: relocated overlay geometry, then reset in the middle of a fill.
    pcx = 4'd15; pcy = 4'd15;
    gnt_mode_o = 0;
    start_fill(49);
    chk("t6_req_o", 16'(rif_o.req), 16'd1);
    chk("t6_row_o", 16'(rif_o.row), 16'd0);
    repeat (20) tick();
    pix(1'b1, 100, 50, 1'b1, C_GRID);
    pix(1'b1, 99, 50, 1'b0, 6'd0);
    pix(1'b1, 228, 178, 1'b1, C_GRID);
    pix(1'b1, 229, 50, 1'b0, 6'd0);
    pix(1'b1, 100, 179, 1'b0, 6'd0);
    pix(1'b1, 228, 49, 1'b0, 6'd0);
    pix(1'b1, 143, 53, 1'b1, val_colour(2'd1));
    start_fill(57);
    tick(); tick();
    chk("t6_midfill_req", 16'(rif_o.req), 16'd1);
    chk("t6_midfill_col", 16'(rif_o.col), 16'd2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", 16'(rif_o.req), 16'd0);
    chk("t6_rst_col", 16'(rif_o.col), 16'd0);
    tick();
    reset_n = 1'b1;
    tick();
    pix(1'b1, 104, 62, 1'b1, C_MISS);
    pix(1'b1, 100 + 43, 53, 1'b1, C_MISS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
